// File: rtl/zl_fifo_wr_arb.sv
// Round-robin arbiter that shares one FIFO write port among several req/ack
// producers, holding each grant for a burst of up to Burst_len beats.
module zl_fifo_wr_arb #(
  parameter int Data_width  = 8,
  parameter int Num_inputs  = 4,
  parameter int Sel_width   = 2,
  parameter int Burst_len   = 16,
  parameter int Burst_width = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [Num_inputs-1:0]            in_req,
  output logic [Num_inputs-1:0]            in_ack,
  input  logic [Num_inputs*Data_width-1:0] in_data,
  output logic                             out_req,
  input  logic                             out_ack,
  output logic [Data_width-1:0]            out_data,
  output logic [Sel_width-1:0]             out_sel,
  output logic                             busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 r_state, w_stateNext;
  logic [Sel_width-1:0]   r_gnt, w_gntNext;
  logic [Sel_width-1:0]   r_last, w_lastNext;
  logic [Burst_width-1:0] r_cnt, w_cntNext;
  logic                   w_xfer;
  logic                   w_release;
  logic [Sel_width:0]     w_pickIdle;
  logic [Sel_width:0]     w_pickGrant;

  // Returns {found, index} of the first request after 'from', wrapping around.
  function automatic logic [Sel_width:0] pick(input logic [Num_inputs-1:0] req,
                                              input logic [Sel_width-1:0]  from);
    logic [Sel_width:0]   res;
    logic [Sel_width-1:0] idx;
    res = '0;
    for (int i = Num_inputs; i >= 1; i--) begin
      idx = Sel_width'((int'(from) + i) % Num_inputs);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_pickIdle  = pick(in_req, r_last);
  assign w_pickGrant = pick(in_req, r_gnt);
  assign w_xfer      = (r_state == GRANT) && in_req[r_gnt] && out_ack;
  assign w_release   = (r_state == GRANT) &&
                       ((w_xfer && (r_cnt == Burst_width'(Burst_len - 1))) ||
                        !in_req[r_gnt]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_last  <= Sel_width'(Num_inputs - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_gnt   <= w_gntNext;
      r_last  <= w_lastNext;
      r_cnt   <= w_cntNext;
    end
  end

  // A release re-picks in the same cycle so the next burst starts without a bubble.
  always_comb begin
    w_stateNext = r_state;
    w_gntNext   = r_gnt;
    w_lastNext  = r_last;
    w_cntNext   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_pickIdle[Sel_width]) begin
          w_stateNext = GRANT;
          w_gntNext   = w_pickIdle[Sel_width-1:0];
          w_lastNext  = w_pickIdle[Sel_width-1:0];
          w_cntNext   = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          if (w_pickGrant[Sel_width]) begin
            w_gntNext  = w_pickGrant[Sel_width-1:0];
            w_lastNext = w_pickGrant[Sel_width-1:0];
            w_cntNext  = '0;
          end else begin
            w_stateNext = IDLE;
          end
        end else if (w_xfer) begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    out_req  = 1'b0;
    out_data = '0;
    out_sel  = '0;
    busy     = 1'b0;
    in_ack   = '0;
    if (r_state == GRANT) begin
      out_req = in_req[r_gnt];
      out_sel = r_gnt;
      busy    = 1'b1;
      for (int i = 0; i < Num_inputs; i++) begin
        if (Sel_width'(i) == r_gnt) begin
          out_data  = in_data[i*Data_width +: Data_width];
          in_ack[i] = out_ack && in_req[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_zl_fifo_wr_arb.sv
// Directed and random checks of zl_fifo_wr_arb using a Burst_len=16 instance (A)
// and a Burst_len=2 instance (B) driven from the same producer stimulus.
module tb_zl_fifo_wr_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  inReq;
  logic [31:0] inData;
  logic        outAck;

  logic [3:0]  aInAck, bInAck;
  logic        aOutReq, bOutReq;
  logic [7:0]  aOutData, bOutData;
  logic [1:0]  aOutSel, bOutSel;
  logic        aBusy, bBusy;

  int checks;
  int errors;

  logic [7:0] dataOf [4];
  logic [5:0] seq [4];
  int         remain [4];
  int         waitBeats [4];

  zl_fifo_wr_arb #(.Data_width(8), .Num_inputs(4), .Sel_width(2),
                   .Burst_len(16), .Burst_width(5)) dutA (
    .clk(clk), .rst(rst), .in_req(inReq), .in_ack(aInAck), .in_data(inData),
    .out_req(aOutReq), .out_ack(outAck), .out_data(aOutData),
    .out_sel(aOutSel), .busy(aBusy));

  zl_fifo_wr_arb #(.Data_width(8), .Num_inputs(4), .Sel_width(2),
                   .Burst_len(2), .Burst_width(2)) dutB (
    .clk(clk), .rst(rst), .in_req(inReq), .in_ack(bInAck), .in_data(inData),
    .out_req(bOutReq), .out_ack(outAck), .out_data(bOutData),
    .out_sel(bOutSel), .busy(bBusy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rst    = 1'b1;
    inReq  = 4'b0000;
    outAck = 1'b1;
    inData = 32'hD3C2B1A0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    inReq  = 4'b0001;
    outAck = 1'b1;
    tick();
    rst = 1'b0;
    inReq = 4'b0000;
    #1;
    checks++;
    if ({aOutReq, aInAck, aBusy} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got req/ack/busy=%b want 000000", {aOutReq, aInAck, aBusy});
    end
    checks++;
    if ({aOutSel, aOutData} !== 10'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got sel=%0d data=%h want 0/00", aOutSel, aOutData);
    end
    checks++;
    if ({bOutReq, bInAck, bBusy} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl_b got %b want 000000", {bOutReq, bInAck, bBusy});
    end
  endtask

  task automatic test_single;
    doReset();
    inReq = 4'b0001;
    #1;
    checks++;
    if ({aBusy, aOutReq, aInAck} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL single_idle got busy/req/ack=%b want 000000", {aBusy, aOutReq, aInAck});
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({aBusy, aOutReq, aOutSel, aInAck, aOutData} !== {1'b1, 1'b1, 2'd0, 4'b0001, 8'hA0}) begin
        errors++;
        $display("[TB] FAIL single_beat%0d got busy=%b req=%b sel=%0d ack=%b data=%h want 1 1 0 0001 a0",
                 k, aBusy, aOutReq, aOutSel, aInAck, aOutData);
      end
      tick();
    end
    inReq = 4'b0000;
    #1;
    checks++;
    if ({aBusy, aOutReq, aInAck} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL single_drop got busy/req/ack=%b want 100000", {aBusy, aOutReq, aInAck});
    end
    tick();
    checks++;
    if (aBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle_after got busy=%b want 0", aBusy);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] expSel [10];
    expSel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    doReset();
    inReq = 4'b1111;
    #1;
    tick();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({bBusy, bOutSel, bInAck, bOutData} !==
          {1'b1, expSel[k], 4'b0001 << expSel[k], dataOf[expSel[k]]}) begin
        errors++;
        $display("[TB] FAIL rr_beat%0d got busy=%b sel=%0d ack=%b data=%h want sel=%0d",
                 k, bBusy, bOutSel, bInAck, bOutData, expSel[k]);
      end
      tick();
    end
  endtask

  task automatic test_full_stall;
    doReset();
    inReq = 4'b0100;
    #1;
    tick();
    inReq = 4'b0110;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({aOutSel, aInAck} !== {2'd2, 4'b0100}) begin
        errors++;
        $display("[TB] FAIL stall_pre%0d got sel=%0d ack=%b want 2 0100", k, aOutSel, aInAck);
      end
      tick();
    end
    outAck = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({aOutReq, aInAck, aOutSel, aOutData, aBusy} !== {1'b1, 4'b0000, 2'd2, 8'hC2, 1'b1}) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d got req=%b ack=%b sel=%0d data=%h busy=%b want 1 0000 2 c2 1",
                 k, aOutReq, aInAck, aOutSel, aOutData, aBusy);
      end
      tick();
    end
    outAck = 1'b1;
    #1;
    for (int k = 0; k < 13; k++) begin
      checks++;
      if ({aOutSel, aInAck, aOutData} !== {2'd2, 4'b0100, 8'hC2}) begin
        errors++;
        $display("[TB] FAIL stall_post%0d got sel=%0d ack=%b data=%h want 2 0100 c2",
                 k, aOutSel, aInAck, aOutData);
      end
      tick();
    end
    checks++;
    if ({aBusy, aOutSel, aInAck} !== {1'b1, 2'd1, 4'b0010}) begin
      errors++;
      $display("[TB] FAIL stall_handover got busy=%b sel=%0d ack=%b want 1 1 0010", aBusy, aOutSel, aInAck);
    end
  endtask

  task automatic test_burst_limit;
    doReset();
    inReq = 4'b0010;
    #1;
    tick();
    for (int k = 0; k < 40; k++) begin
      checks++;
      if ({aBusy, aOutSel, aInAck} !== {1'b1, 2'd1, 4'b0010}) begin
        errors++;
        $display("[TB] FAIL burst_beat%0d got busy=%b sel=%0d ack=%b want 1 1 0010",
                 k, aBusy, aOutSel, aInAck);
      end
      tick();
    end
    inReq = 4'b0000;
    #1;
    tick();
    checks++;
    if (aBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL burst_end got busy=%b want 0", aBusy);
    end
  endtask

  task automatic test_reset_mid_burst;
    doReset();
    inReq = 4'b1000;
    #1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({aOutSel, aInAck} !== {2'd3, 4'b1000}) begin
        errors++;
        $display("[TB] FAIL midrst_beat%0d got sel=%0d ack=%b want 3 1000", k, aOutSel, aInAck);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({aOutReq, aInAck, aBusy, aOutSel, aOutData} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL midrst_idle got req=%b ack=%b busy=%b sel=%0d data=%h want all 0",
               aOutReq, aInAck, aBusy, aOutSel, aOutData);
    end
    inReq = 4'b1111;
    #1;
    tick();
    checks++;
    if ({aOutSel, aInAck} !== {2'd0, 4'b0001}) begin
      errors++;
      $display("[TB] FAIL midrst_first got sel=%0d ack=%b want 0 0001", aOutSel, aInAck);
    end
  endtask

  task automatic test_random;
    logic [3:0] ackSeen;
    int         maxWait;
    doReset();
    for (int i = 0; i < 4; i++) begin
      seq[i]       = 6'd0;
      remain[i]    = 0;
      waitBeats[i] = 0;
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      outAck = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) inData[i*8 +: 8] = {2'(i), seq[i]};
      #1;
      checks++;
      if (!$onehot0(bInAck)) begin
        errors++;
        $display("[TB] FAIL rand_onehot cycle %0d got ack=%b want one-hot or zero", cyc, bInAck);
      end
      ackSeen = bInAck;
      for (int i = 0; i < 4; i++) begin
        if (ackSeen[i]) begin
          checks++;
          if ({bOutSel, bOutData} !== {2'(i), 2'(i), seq[i]}) begin
            errors++;
            $display("[TB] FAIL rand_data cycle %0d got sel=%0d data=%h want sel=%0d data=%h",
                     cyc, bOutSel, bOutData, i, {2'(i), seq[i]});
          end
        end
      end
      maxWait = 0;
      for (int i = 0; i < 4; i++) begin
        if (ackSeen[i] || !inReq[i]) waitBeats[i] = 0;
        else if (ackSeen != 4'b0000) waitBeats[i]++;
        if (waitBeats[i] > maxWait) maxWait = waitBeats[i];
      end
      checks++;
      if (maxWait > 8) begin
        errors++;
        $display("[TB] FAIL rand_fair cycle %0d got wait=%0d beats want <= 8", cyc, maxWait);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        if (ackSeen[i]) begin
          seq[i]++;
          remain[i]--;
          if (remain[i] == 0) inReq[i] = 1'b0;
        end else if (!inReq[i] && ($urandom_range(0, 3) == 0)) begin
          inReq[i]  = 1'b1;
          remain[i] = int'($urandom_range(1, 5));
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    dataOf = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    rst    = 1'b1;
    inReq  = 4'b0000;
    inData = 32'hD3C2B1A0;
    outAck = 1'b1;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_burst_limit();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
